// File: rtl/digit_shift_reg.sv
// rtl/digit_shift_reg.sv - digit-entry shift register for the calculator operand path
// Shifts digits in/out at the LS end, tracks significant-digit count and a sticky overflow flag.
module digit_shift_reg #(
  parameter  int DIGITS = 4,
  parameter  int DW     = 4,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_ld,
  input  logic [DIGITS*DW-1:0] i_d,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [DW-1:0]        i_din,
  output logic [DIGITS*DW-1:0] o_q,
  output logic [CW-1:0]        o_count,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_ovf
);

  logic [DIGITS*DW-1:0] r_q;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;

  logic [DIGITS*DW-1:0] w_q_nxt;
  logic [CW-1:0]        w_count_nxt;
  logic                 w_ovf_nxt;
  logic [CW-1:0]        w_ld_count;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_din_zero;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DIGITS));
  assign w_din_zero = (i_din == '0);

  // Loaded count is one past the most significant nonzero digit.
  always_comb begin
    w_ld_count = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i_d[i*DW +: DW] != '0) begin
        w_ld_count = CW'(i + 1);
      end
    end
  end

  always_comb begin
    w_q_nxt     = r_q;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    if (i_clr) begin
      w_q_nxt     = '0;
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end else if (i_ld) begin
      w_q_nxt     = i_d;
      w_count_nxt = w_ld_count;
      w_ovf_nxt   = 1'b0;
    end else if (i_push && i_pop) begin
      // Replace digit 0; count only moves across the empty/one-digit boundary.
      w_q_nxt = {r_q[DIGITS*DW-1:DW], i_din};
      if (w_empty && !w_din_zero) begin
        w_count_nxt = CW'(1);
      end else if ((r_count == CW'(1)) && w_din_zero) begin
        w_count_nxt = '0;
      end
    end else if (i_push) begin
      if (w_full) begin
        w_ovf_nxt = 1'b1;
      end else if (!(w_empty && w_din_zero)) begin
        w_q_nxt     = {r_q[(DIGITS-1)*DW-1:0], i_din};
        w_count_nxt = r_count + CW'(1);
      end
    end else if (i_pop) begin
      if (!w_empty) begin
        w_q_nxt     = {{DW{1'b0}}, r_q[DIGITS*DW-1:DW]};
        w_count_nxt = r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q     <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign o_q     = r_q;
  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_ovf   = r_ovf;

endmodule
